mem_port_scheduler: RTL and testbench
=====================================

# mem_port_scheduler

Sequences and shares the single byte-wide external memory port between the instruction-fetch path (i-cache miss fill) and the load/store buffer. Each granted request is split into 1, 2 or 4 little-endian byte transfers, and read bytes are reassembled with optional sign extension. The block honours the global pause (`rdy`) and speculative flush (`flush`), and can stall UART writes while the I/O buffer is full. It sits between the i-cache/LSB and the top-level `mem_*` pins.

## Interface
- `ADDR_W`, 32, address width of all address ports
- `IO_HI`, 2'b11, value of `addr[17:16]` that marks the I/O region
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `rdy`  in  1  global ready; low freezes the block
- `flush`  in  1  misprediction flush (ROB wrong commit)
- `mem_din`  in  8  byte returned by memory, one cycle after its address
- `mem_dout`  out  8  write byte
- `mem_a`  out  ADDR_W  byte address
- `mem_wr`  out  1  1 = write
- `io_buffer_full`  in  1  UART transmit buffer full
- `if_req`  in  1  fetch request, level; held until `if_done`
- `if_addr`  in  ADDR_W  fetch address (word)
- `if_done`  out  1  one-cycle pulse; `if_data` valid
- `if_data`  out  32  fetched word
- `ls_req`  in  1  load/store request, level; held until `ls_done`
- `ls_we`  in  1  1 = store
- `ls_size`  in  2  0 = byte, 1 = half, 2 = word (3 is illegal)
- `ls_signed`  in  1  sign-extend loaded data
- `ls_addr`  in  ADDR_W  access address
- `ls_wdata`  in  32  store data, LSB-first
- `ls_done`  out  1  one-cycle pulse; `ls_rdata` valid (loads)
- `ls_rdata`  out  32  load result
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, READ, WRITE, DONE. Byte count N = 1/2/4; byte counter k.
- IDLE, no flush:
  - Only one requester: grant it.
  - Both requesting: grant the one not granted last (round-robin). The priority bit resets to favour LS.
  - Latch addr/size/we/wdata/owner; k = 0.
  - Go to READ if fetch or load, WRITE if store.
- READ:
  - While k < N: `mem_a` = addr+k.
  - For k ≥ 1: capture `mem_din` into byte k-1.
  - k increments each cycle.
  - At k = N, capture the last byte with `mem_a` = 0, then go to DONE.
- WRITE:
  - `mem_wr` = 1, `mem_a` = addr+k, `mem_dout` = wdata byte k.
  - After k = N-1, go to DONE.
- DONE: pulse the owner's `*_done` for one cycle, return to IDLE.
- Loads: zero- or sign-extend to 32 bits per `ls_signed`. Stores leave `ls_rdata` unchanged.
- Address arithmetic is modulo 2^ADDR_W; no alignment checking.
- `flush` high:
  - Aborts READ (fetch or load) at the next edge: go to IDLE, no done pulse.
  - WRITE always completes (stores are committed).
  - In IDLE, requests sampled in the same cycle as `flush` are not granted.
  - A flush in DONE of a read suppresses the pulse.
- `rdy` low:
  - All state holds and `mem_wr` is forced to 0.
  - `mem_din` is held stable by the memory system across a pause, so capture resumes correctly.
- Reset values: state IDLE, `mem_a` 0, `mem_dout` 0, `mem_wr` 0, both dones 0, `if_data` 0, `ls_rdata` 0, `busy` 0, priority = LS.

## Timing
- Grant cycle G = the IDLE cycle in which the request is sampled.
- Read of N bytes:
  - Addresses driven in cycles G+1 … G+N.
  - `*_done` asserted in cycle G+N+2.
  - Word fetch: 6 cycles from grant to done.
- Write of N bytes: bytes driven in cycles G+1 … G+N; `ls_done` in cycle G+N+1.
- The earliest next grant is the cycle after DONE.
- Each `rdy`-low cycle adds one cycle of latency.
- `if_data`/`ls_rdata` are registered and stay stable until the next done for that owner.

## Configuration
- `MEM_IO_STALL_EN` defined:
  - In WRITE, when `addr[17:16] == IO_HI` and `io_buffer_full` = 1, hold k, force `mem_wr` = 0, retry each cycle.
  - Also stall the cycle right after any I/O byte write, to cover the buffer's one-cycle update lag.
- Undefined: `io_buffer_full` is ignored and I/O writes proceed at full rate.

## Structure
- Package `mem_sched_pkg`:
  - state enum
  - size encodings `SZ_B`/`SZ_H`/`SZ_W`
  - owner enum `OWN_IF`/`OWN_LS`
  - `IO_HI` default
  - a byte-count function
- One sub-module `mem_rr_arbiter`: 2-way round-robin grant with registered priority bit, updated only on grant.

## Test plan
- `if_req`, `if_addr` = 0x100, memory 0x100..0x103 = 13 00 00 00 → `mem_a` 0x100..0x103 in G+1..G+4; `if_done` at G+6; `if_data` = 0x00000013.
- Signed byte load at 0x20 with byte 0x80 → `ls_rdata` = 0xFFFFFF80. Same access with `ls_signed` = 0 → 0x00000080.
- Store word 0xDEADBEEF at 0x40 → `mem_dout` EF, BE, AD, DE to 0x40..0x43 with `mem_wr` = 1; `ls_done` at G+5.
- `if_req` and `ls_req` held together from reset → grants LS, IF, LS, IF … alternately.
- `flush` in G+2 of a word fetch → no `if_done`, `busy` low next cycle. `flush` during a store → store completes and `ls_done` pulses.
- With `MEM_IO_STALL_EN`: byte store to 0x30000 while `io_buffer_full` = 1 for 3 cycles → `mem_wr` stays 0 for those cycles; write happens when full drops. `rdy` low 2 cycles mid-fetch → result unchanged, done delayed 2 cycles.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the memory port scheduler.
package mem_sched_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

    // Illegal size 3 is treated as a word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_B:    byte_count = 3'd1;
            SZ_H:    byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction
endpackage

// File: rtl/mem_port_scheduler_if.sv
// Client (i-fetch, load/store) and byte-wide memory pin bundle for the scheduler.
interface mem_port_scheduler_if #(parameter int ADDR_W = 32);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;
    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic              ls_signed;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_port_scheduler_arbiter.sv
// Two-way round-robin grant; the priority bit moves only when a grant is issued.
module mem_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_if,
    input  logic req_ls,
    output logic gnt_if,
    output logic gnt_ls
);
    logic pri_ls;

    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (en) begin
            if (req_ls && (pri_ls || !req_if)) gnt_ls = 1'b1;
            else if (req_if)                   gnt_if = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        pri_ls <= 1'b1;
        else if (gnt_ls) pri_ls <= 1'b0;
        else if (gnt_if) pri_ls <= 1'b1;
    end
endmodule

// File: rtl/mem_port_scheduler.sv
// Shares the byte-wide memory port between i-fetch and load/store, splitting accesses into bytes.
// Define MEM_IO_STALL_EN to throttle I/O-region writes on io_buffer_full.
module mem_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IO_HI_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic flush,
    output logic busy,
    mem_port_scheduler_if.slave bus
);
    state_t            state, state_nxt;
    owner_t            owner;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              sgn, we;
    logic [31:0]       wdata, rbuf, merged, ext;
    logic [2:0]        k, n;
    logic [1:0]        cap_idx;
    logic              gnt_if, gnt_ls, stall;

    assign n       = byte_count(size);
    assign cap_idx = 2'(k - 3'd1);
    assign busy    = (state != ST_IDLE);

    mem_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (state == ST_IDLE && rdy && !flush),
        .req_if (bus.if_req),
        .req_ls (bus.ls_req),
        .gnt_if (gnt_if),
        .gnt_ls (gnt_ls)
    );

`ifdef MEM_IO_STALL_EN
    logic io_region, io_lag;
    assign io_region = (addr[17:16] == IO_HI);
    // The buffer's full flag lags a write by a cycle, so every I/O byte costs one dead cycle.
    assign stall = (state == ST_WRITE) && io_region && (bus.io_buffer_full || io_lag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     io_lag <= 1'b0;
        else if (rdy) io_lag <= bus.mem_wr && io_region;
    end
`else
    wire unused_io = bus.io_buffer_full | (|IO_HI);
    assign stall = 1'b0;
`endif

    // Last byte comes straight from mem_din so the result is ready on entry to DONE.
    always_comb begin
        merged = rbuf;
        merged[{cap_idx, 3'b000} +: 8] = bus.mem_din;
    end

    always_comb begin
        ext = merged;
        case (size)
            SZ_B:    ext = {{24{sgn & merged[7]}}, merged[7:0]};
            SZ_H:    ext = {{16{sgn & merged[15]}}, merged[15:0]};
            default: ext = merged;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     state <= ST_IDLE;
        else if (rdy) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (gnt_ls)      state_nxt = bus.ls_we ? ST_WRITE : ST_READ;
                      else if (gnt_if) state_nxt = ST_READ;
            ST_READ:  if (flush)       state_nxt = ST_IDLE;
                      else if (k == n) state_nxt = ST_DONE;
            ST_WRITE: if (!stall && k == n - 3'd1) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_a    = '0;
        bus.mem_dout = '0;
        bus.mem_wr   = 1'b0;
        bus.if_done  = 1'b0;
        bus.ls_done  = 1'b0;
        case (state)
            ST_READ:  if (k != n) bus.mem_a = addr + ADDR_W'(k);
            ST_WRITE: begin
                bus.mem_a    = addr + ADDR_W'(k);
                bus.mem_dout = wdata[{k[1:0], 3'b000} +: 8];
                bus.mem_wr   = rdy && !stall;
            end
            ST_DONE:  if (rdy && !(flush && !we)) begin
                if (owner == OWN_IF) bus.if_done = 1'b1;
                else                 bus.ls_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner        <= OWN_LS;
            addr         <= '0;
            size         <= SZ_W;
            sgn          <= 1'b0;
            we           <= 1'b0;
            wdata        <= '0;
            k            <= '0;
            rbuf         <= '0;
            bus.if_data  <= '0;
            bus.ls_rdata <= '0;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (gnt_ls) begin
                        owner <= OWN_LS;
                        addr  <= bus.ls_addr;
                        size  <= bus.ls_size;
                        sgn   <= bus.ls_signed;
                        we    <= bus.ls_we;
                        wdata <= bus.ls_wdata;
                        k     <= '0;
                    end else if (gnt_if) begin
                        owner <= OWN_IF;
                        addr  <= bus.if_addr;
                        size  <= SZ_W;
                        sgn   <= 1'b0;
                        we    <= 1'b0;
                        k     <= '0;
                    end
                end
                ST_READ: begin
                    k <= k + 3'd1;
                    if (k != 3'd0) rbuf[{cap_idx, 3'b000} +: 8] <= bus.mem_din;
                    if (k == n && !flush) begin
                        if (owner == OWN_IF) bus.if_data  <= ext;
                        else                 bus.ls_rdata <= ext;
                    end
                end
                ST_WRITE: if (!stall) k <= k + 3'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed table-driven bench for mem_port_scheduler with a byte memory model.
module tb_mem_port_scheduler;
    import mem_sched_pkg::*;

    logic clk, rst, rdy, flush, busy;
    mem_port_scheduler_if #(.ADDR_W(32)) bus();

    mem_port_scheduler #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .busy(busy), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [1024];
    always @(posedge clk) if (rdy) bus.mem_din <= mem[bus.mem_a[9:0]];

    typedef struct {
        logic        is_if;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_word;
        int          n;
        int          exp_done;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [12];
    int n_vec, n_err;

    logic [31:0] obs_a    [16];
    logic [7:0]  obs_dout [16];
    logic        obs_wr   [16];
    logic        obs_ifd  [16];
    logic        obs_lsd  [16];
    logic        obs_busy [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issues one request and records cycles G+1..G+15; pattern bit j is the level during G+j.
    task automatic run(input vec_t v, input logic [15:0] rdyp, input logic [15:0] flp,
                       input logic [15:0] fullp, input int drop_at);
        logic [9:0] ix;
        @(negedge clk);
        if (!v.we)
            for (int i = 0; i < v.n; i++) begin
                ix = 10'(v.addr + 32'(i));
                mem[ix] = v.mem_word[8*i +: 8];
            end
        if (v.is_if) begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end else begin
            bus.ls_req = 1'b1; bus.ls_we = v.we; bus.ls_size = v.size;
            bus.ls_signed = v.sgn; bus.ls_addr = v.addr; bus.ls_wdata = v.wdata;
        end
        rdy = rdyp[0]; flush = flp[0]; bus.io_buffer_full = fullp[0];
        for (int j = 1; j < 16; j++) begin
            @(posedge clk); #1;
            rdy = rdyp[j]; flush = flp[j]; bus.io_buffer_full = fullp[j];
            if (j == drop_at) begin bus.if_req = 1'b0; bus.ls_req = 1'b0; end
            @(negedge clk);
            obs_a[j] = bus.mem_a; obs_dout[j] = bus.mem_dout; obs_wr[j] = bus.mem_wr;
            obs_ifd[j] = bus.if_done; obs_lsd[j] = bus.ls_done; obs_busy[j] = busy;
            if (bus.if_done || bus.ls_done) begin bus.if_req = 1'b0; bus.ls_req = 1'b0; end
        end
        rdy = 1'b1; flush = 1'b0; bus.io_buffer_full = 1'b0;
    endtask

    function automatic int done_at(input logic is_if);
        done_at = 0;
        for (int j = 15; j >= 1; j--) if (is_if ? obs_ifd[j] : obs_lsd[j]) done_at = j;
    endfunction

    function automatic int pulses();
        pulses = 0;
        for (int j = 1; j < 16; j++) if (obs_ifd[j] || obs_lsd[j]) pulses++;
    endfunction

    task automatic check_vec(input int id, input vec_t v);
        chk($sformatf("v%0d done_cycle", id), done_at(v.is_if), v.exp_done);
        chk($sformatf("v%0d pulses", id), pulses(), 1);
        for (int i = 0; i < v.n; i++) begin
            chk($sformatf("v%0d mem_a[%0d]", id, i), obs_a[1+i], v.addr + 32'(i));
            chk($sformatf("v%0d mem_wr[%0d]", id, i), 32'(obs_wr[1+i]), 32'(v.we));
            if (v.we) chk($sformatf("v%0d mem_dout[%0d]", id, i), 32'(obs_dout[1+i]), 32'(v.wdata[8*i +: 8]));
        end
        if (!v.we) chk($sformatf("v%0d tail_addr", id), obs_a[v.n+1], 32'h0);
        else       chk($sformatf("v%0d tail_wr", id), 32'(obs_wr[v.n+1]), 32'h0);
        chk($sformatf("v%0d busy_after", id), 32'(obs_busy[v.exp_done+1]), 32'h0);
        chk($sformatf("v%0d data", id), v.is_if ? bus.if_data : bus.ls_rdata, v.exp_data);
    endtask

    initial begin
        vec_t v;
        int got;
        logic [3:0] order;
        n_vec = 0; n_err = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        //        is_if we    size  sgn   addr          wdata         mem_word      n  done exp_data
        tbl[0]  = '{1'b1, 1'b0, SZ_W, 1'b0, 32'h00000100, 32'h0,        32'h00000013, 4, 6, 32'h00000013};
        tbl[1]  = '{1'b0, 1'b0, SZ_B, 1'b1, 32'h00000020, 32'h0,        32'h00000080, 1, 3, 32'hFFFFFF80};
        tbl[2]  = '{1'b0, 1'b0, SZ_B, 1'b0, 32'h00000020, 32'h0,        32'h00000080, 1, 3, 32'h00000080};
        tbl[3]  = '{1'b0, 1'b1, SZ_W, 1'b0, 32'h00000040, 32'hDEADBEEF, 32'h0,        4, 5, 32'h00000080};
        tbl[4]  = '{1'b0, 1'b0, SZ_H, 1'b1, 32'h00000051, 32'h0,        32'h00009234, 2, 4, 32'hFFFF9234};
        tbl[5]  = '{1'b0, 1'b0, SZ_H, 1'b0, 32'h00000051, 32'h0,        32'h00009234, 2, 4, 32'h00009234};
        tbl[6]  = '{1'b0, 1'b1, SZ_B, 1'b0, 32'h00000060, 32'h123456A5, 32'h0,        1, 2, 32'h00009234};
        tbl[7]  = '{1'b0, 1'b1, SZ_H, 1'b0, 32'h00000070, 32'h00001234, 32'h0,        2, 3, 32'h00009234};
        tbl[8]  = '{1'b0, 1'b0, SZ_W, 1'b0, 32'h00000080, 32'h0,        32'h12345678, 4, 6, 32'h12345678};
        tbl[9]  = '{1'b0, 1'b0, SZ_W, 1'b1, 32'h00000090, 32'h0,        32'hF4030201, 4, 6, 32'hF4030201};
        tbl[10] = '{1'b1, 1'b0, SZ_W, 1'b0, 32'hFFFFFFFE, 32'h0,        32'hA1B2C3D4, 4, 6, 32'hA1B2C3D4};
        tbl[11] = '{1'b0, 1'b0, SZ_B, 1'b1, 32'h00000021, 32'h0,        32'h0000007F, 1, 3, 32'h0000007F};

        // Reset with both requesters already asserted.
        mem[10'h020] = 8'h80;
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        bus.io_buffer_full = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = SZ_B; bus.ls_signed = 1'b0;
        bus.ls_addr = 32'h20; bus.ls_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst busy",     32'(busy), 32'h0);
        chk("rst mem_a",    bus.mem_a, 32'h0);
        chk("rst mem_wr",   32'(bus.mem_wr), 32'h0);
        chk("rst mem_dout", 32'(bus.mem_dout), 32'h0);
        chk("rst if_done",  32'(bus.if_done), 32'h0);
        chk("rst ls_done",  32'(bus.ls_done), 32'h0);
        chk("rst if_data",  bus.if_data, 32'h0);
        chk("rst ls_rdata", bus.ls_rdata, 32'h0);
        rst = 1'b1;

        // Round-robin: LS favoured out of reset, then strict alternation.
        got = 0; order = 4'bxxxx;
        for (int c = 0; c < 80 && got < 4; c++) begin
            @(negedge clk);
            if (bus.ls_done)      begin order[got] = 1'b1; got++; end
            else if (bus.if_done) begin order[got] = 1'b0; got++; end
        end
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        chk("rr grants", got, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr grant%0d is_ls", i), 32'(order[i]), (i % 2 == 0) ? 32'h1 : 32'h0);

        for (int i = 0; i < 12; i++) begin
            run(tbl[i], 16'hFFFF, 16'h0, 16'h0, 0);
            check_vec(i, tbl[i]);
        end

        // Request sampled together with flush in IDLE is not granted.
        @(negedge clk);
        mem[10'h020] = 8'h3C;
        bus.ls_we = 1'b0; bus.ls_size = SZ_B; bus.ls_signed = 1'b1; bus.ls_addr = 32'h20;
        bus.ls_req = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush no grant", 32'(busy), 32'h0);
        flush = 1'b0;
        @(negedge clk);
        chk("idle_flush grant after", 32'(busy), 32'h1);
        for (int j = 0; j < 10 && !bus.ls_done; j++) @(negedge clk);
        chk("idle_flush ls_done", 32'(bus.ls_done), 32'h1);
        bus.ls_req = 1'b0;
        chk("idle_flush data", bus.ls_rdata, 32'h0000003C);

        // Flush in G+2 of a word fetch aborts it.
        v = '{1'b1, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h55555555, 4, 0, 32'h0};
        run(v, 16'hFFFF, 16'h0004, 16'h0, 3);
        chk("fetch_flush pulses", pulses(), 0);
        chk("fetch_flush busy G+3", 32'(obs_busy[3]), 32'h0);
        chk("fetch_flush if_data kept", bus.if_data, 32'hA1B2C3D4);

        // Flush during a store does not stop it.
        v = '{1'b0, 1'b1, SZ_W, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 4, 5, 32'h0};
        run(v, 16'hFFFF, 16'h0004, 16'h0, 0);
        chk("store_flush done_cycle", done_at(1'b0), 5);
        chk("store_flush wr G+3", 32'(obs_wr[3]), 32'h1);
        chk("store_flush dout G+4", 32'(obs_dout[4]), 32'hCA);

        // rdy low in G+2,G+3 of a fetch: same data, two cycles later.
        v = '{1'b1, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h44332211, 4, 8, 32'h0};
        run(v, ~16'h000C, 16'h0, 16'h0, 0);
        chk("pause_fetch done_cycle", done_at(1'b1), 8);
        chk("pause_fetch mem_a G+4", obs_a[4], 32'h101);
        chk("pause_fetch mem_a G+5", obs_a[5], 32'h102);
        chk("pause_fetch data", bus.if_data, 32'h44332211);

        // rdy low during the first write cycle masks mem_wr.
        v = '{1'b0, 1'b1, SZ_B, 1'b0, 32'h60, 32'h000000A5, 32'h0, 1, 3, 32'h0};
        run(v, ~16'h0002, 16'h0, 16'h0, 0);
        chk("pause_store wr G+1", 32'(obs_wr[1]), 32'h0);
        chk("pause_store wr G+2", 32'(obs_wr[2]), 32'h1);
        chk("pause_store done_cycle", done_at(1'b0), 3);

`ifdef MEM_IO_STALL_EN
        // Buffer full through G+3: byte lands in G+4.
        v = '{1'b0, 1'b1, SZ_B, 1'b0, 32'h30000, 32'h0000005A, 32'h0, 1, 5, 32'h0};
        run(v, 16'hFFFF, 16'h0, 16'h000F, 0);
        for (int j = 1; j <= 3; j++) chk($sformatf("io_full wr G+%0d", j), 32'(obs_wr[j]), 32'h0);
        chk("io_full wr G+4", 32'(obs_wr[4]), 32'h1);
        chk("io_full a G+4", obs_a[4], 32'h30000);
        chk("io_full dout G+4", 32'(obs_dout[4]), 32'h5A);
        chk("io_full done_cycle", done_at(1'b0), 5);
        // One dead cycle after each I/O byte.
        v = '{1'b0, 1'b1, SZ_H, 1'b0, 32'h30010, 32'h0000BBAA, 32'h0, 2, 4, 32'h0};
        run(v, 16'hFFFF, 16'h0, 16'h0, 0);
        chk("io_lag wr G+1", 32'(obs_wr[1]), 32'h1);
        chk("io_lag wr G+2", 32'(obs_wr[2]), 32'h0);
        chk("io_lag wr G+3", 32'(obs_wr[3]), 32'h1);
        chk("io_lag dout G+3", 32'(obs_dout[3]), 32'hBB);
        chk("io_lag done_cycle", done_at(1'b0), 4);
`else
        // Without the stall option a full buffer is ignored.
        v = '{1'b0, 1'b1, SZ_H, 1'b0, 32'h30010, 32'h0000BBAA, 32'h0, 2, 3, 32'h0};
        run(v, 16'hFFFF, 16'h0, 16'hFFFF, 0);
        chk("io_nostall wr G+1", 32'(obs_wr[1]), 32'h1);
        chk("io_nostall wr G+2", 32'(obs_wr[2]), 32'h1);
        chk("io_nostall dout G+2", 32'(obs_dout[2]), 32'hBB);
        chk("io_nostall done_cycle", done_at(1'b0), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
